// File: rtl/ws2812_multi_tx.sv
// ws2812_multi_tx: bit-synchronous multi-string WS2812 driver fed by a pixel RAM.
// Optional macro WS2812_RGBW_EN selects 32-bit GRBW pixels (24-bit GRB otherwise).
module ws2812_multi_tx #(
    parameter int CHANNELS    = 4,
    parameter int LEDS_PER_CH = 64,
    parameter int ADDR_W      = 13,
    parameter int T0H         = 17,
    parameter int T1H         = 34,
    parameter int TBIT        = 60,
    parameter int TLATCH      = 2880,
`ifdef WS2812_RGBW_EN
    localparam int PIX_W      = 32
`else
    localparam int PIX_W      = 24
`endif
) (
    input  logic                clk_sb,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   n_leds,
    output logic                busy,
    output logic                done,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [PIX_W-1:0]    mem_rd_data,
    output logic [CHANNELS-1:0] led_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PREF  = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    localparam int PH_W = $clog2(TBIT);
    localparam int BI_W = $clog2(PIX_W);
    localparam int LT_W = $clog2(TLATCH);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [1:0]          state;
    logic [ADDR_W-1:0]   n_lat;
    logic [ADDR_W-1:0]   led_idx;
    logic [PH_W-1:0]     ph;
    logic [BI_W-1:0]     bit_idx;
    logic [LT_W-1:0]     lat_cnt;
    logic [CH_W-1:0]     rd_ch;
    logic [CH_W-1:0]     cap_ch;
    logic                cap_vld;
    logic [PIX_W-1:0]    shadow [CHANNELS];
    logic [PIX_W-1:0]    shreg  [CHANNELS];
    logic [PIX_W-1:0]    fill   [CHANNELS];
    logic [CHANNELS-1:0] hi_nx;
    logic [ADDR_W-1:0]   n_clamp;
    logic [ADDR_W-1:0]   nxt_led;
    logic [ADDR_W-1:0]   rd_base;
    logic                pref_done;
    logic                bit_end;
    logic                led_end;
    logic                load_first;
    logic                load_next;
    logic                rd_go;

    // Frame bookkeeping: clamp, bit/LED boundaries, next-LED prefetch trigger
    always_comb begin
        n_clamp = (n_leds > ADDR_W'(LEDS_PER_CH)) ? ADDR_W'(LEDS_PER_CH) : n_leds;
        pref_done = cap_vld && (cap_ch == CH_W'(CHANNELS - 1));
        bit_end = (ph == PH_W'(TBIT - 1));
        led_end = bit_end && (bit_idx == BI_W'(PIX_W - 1));
        load_first = (state == S_PREF) && pref_done;
        load_next = (state == S_SEND) && led_end
                    && ((led_idx + ADDR_W'(1)) < n_lat);
        nxt_led = load_first ? ADDR_W'(1) : (led_idx + ADDR_W'(2));
        rd_go = ((state == S_IDLE) && start && (n_clamp != '0))
                || ((load_first || load_next) && (nxt_led < n_lat));
        rd_base = (state == S_IDLE) ? '0 : nxt_led;
        for (int c = 0; c < CHANNELS; c++) begin
            fill[c] = (cap_vld && (cap_ch == CH_W'(c))) ? mem_rd_data : shadow[c];
            hi_nx[c] = (int'(ph) + 1) < (shreg[c][PIX_W-1] ? T1H : T0H);
        end
    end

    // Read sequencer: one word per channel on consecutive cycles
    always_ff @(posedge clk_sb or negedge reset_n) begin
        if (!reset_n) begin
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            rd_ch     <= '0;
            cap_vld   <= 1'b0;
            cap_ch    <= '0;
        end else begin
            cap_vld <= mem_rd_en;
            cap_ch  <= rd_ch;
            if (mem_rd_en) begin
                if (rd_ch == CH_W'(CHANNELS - 1)) begin
                    mem_rd_en <= 1'b0;
                end else begin
                    rd_ch    <= rd_ch + CH_W'(1);
                    mem_addr <= mem_addr + ADDR_W'(LEDS_PER_CH);
                end
            end else if (rd_go) begin
                mem_rd_en <= 1'b1;
                mem_addr  <= rd_base;
                rd_ch     <= '0;
            end
        end
    end

    // Shadow buffer: catches the returned word one cycle after each strobe
    always_ff @(posedge clk_sb or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) shadow[c] <= '0;
        end else if (cap_vld) begin
            for (int c = 0; c < CHANNELS; c++)
                if (cap_ch == CH_W'(c)) shadow[c] <= mem_rd_data;
        end
    end

    // Frame FSM and registered line drivers
    always_ff @(posedge clk_sb or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            n_lat   <= '0;
            led_idx <= '0;
            ph      <= '0;
            bit_idx <= '0;
            lat_cnt <= '0;
            led_out <= '0;
            for (int c = 0; c < CHANNELS; c++) shreg[c] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        n_lat   <= n_clamp;
                        led_idx <= '0;
                        lat_cnt <= '0;
                        state   <= (n_clamp == '0) ? S_LATCH : S_PREF;
                    end
                end
                S_PREF: begin
                    if (pref_done) begin
                        state   <= S_SEND;
                        ph      <= '0;
                        bit_idx <= '0;
                        led_idx <= '0;
                        led_out <= '1;
                        for (int c = 0; c < CHANNELS; c++) shreg[c] <= fill[c];
                    end
                end
                S_SEND: begin
                    if (!bit_end) begin
                        ph      <= ph + PH_W'(1);
                        led_out <= hi_nx;
                    end else begin
                        ph <= '0;
                        if (!led_end) begin
                            bit_idx <= bit_idx + BI_W'(1);
                            led_out <= '1;
                            for (int c = 0; c < CHANNELS; c++)
                                shreg[c] <= shreg[c] << 1;
                        end else if (load_next) begin
                            bit_idx <= '0;
                            led_idx <= led_idx + ADDR_W'(1);
                            led_out <= '1;
                            for (int c = 0; c < CHANNELS; c++) shreg[c] <= fill[c];
                        end else begin
                            state   <= S_LATCH;
                            lat_cnt <= '0;
                            led_out <= '0;
                        end
                    end
                end
                S_LATCH: begin
                    lat_cnt <= lat_cnt + LT_W'(1);
                    if (lat_cnt == LT_W'(TLATCH - 2)) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                    if (lat_cnt == LT_W'(TLATCH - 1)) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_multi_tx.sv
// tb_ws2812_multi_tx: randomized self-checking bench for ws2812_multi_tx.
// A second instance with short bit timing carries the long clamped frame.
`timescale 1ns/1ps
module tb_ws2812_multi_tx;

`ifdef WS2812_RGBW_EN
    localparam int P = 32;
`else
    localparam int P = 24;
`endif
    localparam int C  = 4;
    localparam int L  = 64;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start   [2];
    logic [AW-1:0] n_leds  [2];
    logic          busy    [2];
    logic          done    [2];
    logic          rd_en   [2];
    logic [AW-1:0] addr    [2];
    logic [P-1:0]  rd_data [2];
    logic [C-1:0]  led     [2];

    logic [P-1:0]  mem [C*L];
    int            rd_q0[$];
    int            rd_q1[$];
    int            done_cnt0 = 0;

    logic [C-1:0]  wave[$];
    logic          bsy[$];
    logic [C-1:0]  exp_w[$];
    int            exp_rd[$];
    int            exp_done;
    int            done_idx;
    bit            timed_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ws2812_multi_tx #(
        .CHANNELS(C), .LEDS_PER_CH(L), .ADDR_W(AW)
    ) u_main (
        .clk_sb(clk), .reset_n(rst_n), .start(start[0]), .n_leds(n_leds[0]),
        .busy(busy[0]), .done(done[0]), .mem_rd_en(rd_en[0]),
        .mem_addr(addr[0]), .mem_rd_data(rd_data[0]), .led_out(led[0])
    );

    ws2812_multi_tx #(
        .CHANNELS(C), .LEDS_PER_CH(L), .ADDR_W(AW),
        .T0H(2), .T1H(5), .TBIT(8), .TLATCH(16)
    ) u_fast (
        .clk_sb(clk), .reset_n(rst_n), .start(start[1]), .n_leds(n_leds[1]),
        .busy(busy[1]), .done(done[1]), .mem_rd_en(rd_en[1]),
        .mem_addr(addr[1]), .mem_rd_data(rd_data[1]), .led_out(led[1])
    );

    // Pixel RAM with one-cycle read latency, plus read and done logging
    always @(posedge clk) begin
        if (rd_en[0]) begin
            rd_data[0] <= mem[addr[0][7:0]];
            rd_q0.push_back(int'(addr[0]));
        end
        if (rd_en[1]) begin
            rd_data[1] <= mem[addr[1][7:0]];
            rd_q1.push_back(int'(addr[1]));
        end
        if (done[0] === 1'b1) done_cnt0 <= done_cnt0 + 1;
    end

    function automatic int t_bit(input int s);
        return (s == 0) ? 60 : 8;
    endfunction

    function automatic int t_high(input int s, input logic b);
        if (s == 0) return b ? 34 : 17;
        return b ? 5 : 2;
    endfunction

    function automatic int t_latch(input int s);
        return (s == 0) ? 2880 : 16;
    endfunction

    // Expected line levels per cycle after accept, and the read address list
    function automatic void build_model(input int s, input int n_req);
        int n;
        n = (n_req > L) ? L : n_req;
        exp_w.delete();
        exp_rd.delete();
        if (n > 0) begin
            for (int i = 0; i <= C; i++) exp_w.push_back('0);
            for (int j = 0; j < n; j++)
                for (int b = 0; b < P; b++)
                    for (int t = 0; t < t_bit(s); t++) begin
                        logic [C-1:0] v;
                        for (int ch = 0; ch < C; ch++) begin
                            logic [P-1:0] w;
                            w = mem[ch*L + j];
                            v[ch] = (t < t_high(s, w[P-1-b]));
                        end
                        exp_w.push_back(v);
                    end
            for (int j = 0; j < n; j++)
                for (int ch = 0; ch < C; ch++) exp_rd.push_back(ch*L + j);
        end
        for (int i = 0; i < t_latch(s); i++) exp_w.push_back('0);
        exp_done = exp_w.size() - 1;
    endfunction

    function automatic void fill_mem();
        for (int i = 0; i < C*L; i++) mem[i] = P'($urandom);
    endfunction

    function automatic int first_rise();
        foreach (wave[i]) if (wave[i] != '0) return i;
        return -1;
    endfunction

    // Pulse start, then sample one cycle per negedge until done (or cut)
    task automatic run_frame(input int s, input int n, input int poke,
                             input int cut, input int budget);
        wave.delete();
        bsy.delete();
        if (s == 0) rd_q0.delete();
        else rd_q1.delete();
        done_idx = -1;
        timed_out = 1'b0;
        @(negedge clk);
        n_leds[s] = AW'(n);
        start[s] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < budget; i++) begin
            start[s] = (i == poke);
            if (i == poke) n_leds[s] = AW'(1);
            wave.push_back(led[s]);
            bsy.push_back(busy[s]);
            if (done[s] === 1'b1) begin
                done_idx = i;
                break;
            end
            if (i == cut) break;
            @(negedge clk);
        end
        start[s] = 1'b0;
        if (done_idx < 0 && cut < 0) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        n_leds[0] = '0;
        n_leds[1] = '0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b want 0", busy[0]);
        end
        n_cmp++;
        if (done[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done: got %b want 0", done[0]);
        end
        n_cmp++;
        if (rd_en[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rd_en: got %b want 0", rd_en[0]);
        end
        n_cmp++;
        if (addr[0] !== '0) begin
            n_err++;
            $display("FAIL reset_addr: got %h want 0", addr[0]);
        end
        n_cmp++;
        if (led[0] !== '0 || led[1] !== '0) begin
            n_err++;
            $display("FAIL reset_led: got %b/%b want 0", led[0], led[1]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy[0] !== 1'b0 || led[0] !== '0) begin
            n_err++;
            $display("FAIL idle_after_reset: busy %b led %b want 0 0", busy[0], led[0]);
        end
    endtask

    task automatic test_two_led();
        int nbad;
        int bad_at;
        int rise;
        fill_mem();
        mem[0] = P'(32'hFF0000);
        mem[1] = P'(32'h000001);
        build_model(0, 2);
        run_frame(0, 2, -1, -1, 10000);
        n_cmp++;
        if (timed_out || done_idx != exp_done) begin
            n_err++;
            $display("FAIL two_led_done: got idx %0d want %0d", done_idx, exp_done);
        end
        rise = first_rise();
        n_cmp++;
        if (rise != C + 1 || done_idx - rise != 2*P*60 + 2880 - 1) begin
            n_err++;
            $display("FAIL two_led_timing: rise %0d done %0d want rise %0d span %0d",
                     rise, done_idx, C + 1, 2*P*60 + 2880 - 1);
        end
        nbad = 0;
        bad_at = -1;
        foreach (exp_w[i])
            if (i >= wave.size() || wave[i] !== exp_w[i]) begin
                if (bad_at < 0) bad_at = i;
                nbad++;
            end
        n_cmp++;
        if (nbad != 0 || wave.size() != exp_w.size()) begin
            n_err++;
            $display("FAIL two_led_wave: %0d bad cycles, first %0d, len %0d want %0d",
                     nbad, bad_at, wave.size(), exp_w.size());
        end
        nbad = (rd_q0.size() != exp_rd.size()) ? 1 : 0;
        if (nbad == 0) foreach (exp_rd[i]) if (rd_q0[i] != exp_rd[i]) nbad++;
        n_cmp++;
        if (nbad != 0) begin
            n_err++;
            $display("FAIL two_led_reads: got %0d reads want %0d in order",
                     rd_q0.size(), exp_rd.size());
        end
        nbad = 0;
        foreach (bsy[i]) if (bsy[i] !== (i != done_idx)) nbad++;
        n_cmp++;
        if (nbad != 0) begin
            n_err++;
            $display("FAIL two_led_busy: %0d cycles wrong, want high until done", nbad);
        end
`ifndef WS2812_RGBW_EN
        begin
            int runs[$];
            int len;
            len = 0;
            foreach (wave[i]) begin
                if (wave[i][0]) len++;
                else if (len > 0) begin
                    runs.push_back(len);
                    len = 0;
                end
            end
            nbad = (runs.size() != 48) ? 1 : 0;
            if (nbad == 0)
                foreach (runs[i])
                    if (runs[i] != ((i < 8 || i == 47) ? 34 : 17)) nbad++;
            n_cmp++;
            if (nbad != 0) begin
                n_err++;
                $display("FAIL two_led_ch0_runs: got %0d runs (%0d bad) want 48",
                         runs.size(), nbad);
            end
        end
`endif
    endtask

    task automatic test_zero_leds();
        int nhigh;
        fill_mem();
        run_frame(0, 0, -1, -1, 5000);
        n_cmp++;
        if (timed_out || done_idx != 2879) begin
            n_err++;
            $display("FAIL zero_done: got idx %0d want 2879", done_idx);
        end
        n_cmp++;
        if (rd_q0.size() != 0) begin
            n_err++;
            $display("FAIL zero_reads: got %0d want 0", rd_q0.size());
        end
        nhigh = 0;
        foreach (wave[i]) if (wave[i] !== '0) nhigh++;
        n_cmp++;
        if (nhigh != 0) begin
            n_err++;
            $display("FAIL zero_led: got %0d high cycles want 0", nhigh);
        end
    endtask

    task automatic test_clamp();
        int nbad;
        fill_mem();
        build_model(1, 100);
        run_frame(1, 100, -1, -1, 30000);
        n_cmp++;
        if (rd_q1.size() != C*L) begin
            n_err++;
            $display("FAIL clamp_read_count: got %0d want %0d", rd_q1.size(), C*L);
        end
        n_cmp++;
        if (rd_q1.size() == 0 || rd_q1[rd_q1.size()-1] != 255) begin
            n_err++;
            $display("FAIL clamp_last_addr: got %0d want 255",
                     (rd_q1.size() == 0) ? -1 : rd_q1[rd_q1.size()-1]);
        end
        n_cmp++;
        if (timed_out || done_idx != exp_done) begin
            n_err++;
            $display("FAIL clamp_done: got idx %0d want %0d", done_idx, exp_done);
        end
        nbad = 0;
        foreach (exp_w[i]) if (i >= wave.size() || wave[i] !== exp_w[i]) nbad++;
        n_cmp++;
        if (nbad != 0) begin
            n_err++;
            $display("FAIL clamp_wave: got %0d bad cycles want 0", nbad);
        end
    endtask

    task automatic test_start_ignored();
        int nbad;
        fill_mem();
        build_model(0, 2);
        run_frame(0, 2, C + 101, -1, 10000);
        n_cmp++;
        if (timed_out || done_idx != exp_done) begin
            n_err++;
            $display("FAIL ignore_done: got idx %0d want %0d", done_idx, exp_done);
        end
        n_cmp++;
        if (rd_q0.size() != exp_rd.size()) begin
            n_err++;
            $display("FAIL ignore_reads: got %0d want %0d", rd_q0.size(), exp_rd.size());
        end
        nbad = 0;
        foreach (exp_w[i]) if (i >= wave.size() || wave[i] !== exp_w[i]) nbad++;
        n_cmp++;
        if (nbad != 0) begin
            n_err++;
            $display("FAIL ignore_wave: got %0d bad cycles want 0", nbad);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy[0] !== 1'b0 || rd_q0.size() != exp_rd.size()) begin
            n_err++;
            $display("FAIL ignore_no_refire: busy %b reads %0d want 0 %0d",
                     busy[0], rd_q0.size(), exp_rd.size());
        end
    endtask

    task automatic test_reset_mid_send();
        int cut;
        int d0;
        int nbad;
        fill_mem();
        build_model(0, 2);
        cut = C + 6;
        run_frame(0, 2, -1, cut, 10000);
        n_cmp++;
        if (wave.size() != cut + 1 || wave[cut] !== exp_w[cut]) begin
            n_err++;
            $display("FAIL midrst_pre_led: got %b want %b", led[0], exp_w[cut]);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (led[0] !== '0 || busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_async: led %b busy %b want 0 0", led[0], busy[0]);
        end
        d0 = done_cnt0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2880 + 100) @(negedge clk);
        n_cmp++;
        if (done_cnt0 != d0 || busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_no_done: got %0d pulses busy %b want 0 0",
                     done_cnt0 - d0, busy[0]);
        end
        build_model(0, 1);
        run_frame(0, 1, -1, -1, 10000);
        n_cmp++;
        if (rd_q0.size() != C || rd_q0[0] != 0) begin
            n_err++;
            $display("FAIL midrst_restart_addr: got %0d reads first %0d want %0d first 0",
                     rd_q0.size(), (rd_q0.size() == 0) ? -1 : rd_q0[0], C);
        end
        nbad = 0;
        foreach (exp_w[i]) if (i >= wave.size() || wave[i] !== exp_w[i]) nbad++;
        n_cmp++;
        if (nbad != 0 || timed_out || done_idx != exp_done) begin
            n_err++;
            $display("FAIL midrst_restart_frame: %0d bad cycles, done %0d want %0d",
                     nbad, done_idx, exp_done);
        end
    endtask

    task automatic test_single_led();
        int rise;
        int nbad;
        fill_mem();
        build_model(0, 1);
        run_frame(0, 1, -1, -1, 10000);
        rise = first_rise();
        n_cmp++;
        if (timed_out || done_idx - rise != P*60 + 2880 - 1) begin
            n_err++;
            $display("FAIL single_span: got %0d want %0d", done_idx - rise, P*60 + 2880 - 1);
        end
        nbad = 0;
        for (int ch = 0; ch < C; ch++) begin
            int rises;
            rises = 0;
            for (int i = 1; i < wave.size(); i++)
                if (wave[i][ch] && !wave[i-1][ch]) rises++;
            if (rises != P) nbad++;
        end
        n_cmp++;
        if (nbad != 0) begin
            n_err++;
            $display("FAIL single_bit_periods: %0d channels without %0d periods", nbad, P);
        end
        nbad = 0;
        foreach (exp_w[i]) if (i >= wave.size() || wave[i] !== exp_w[i]) nbad++;
        n_cmp++;
        if (nbad != 0) begin
            n_err++;
            $display("FAIL single_wave: got %0d bad cycles want 0", nbad);
        end
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 4; k++) begin
            int n;
            int nbad;
            fill_mem();
            n = $urandom_range(0, 12);
            build_model(1, n);
            run_frame(1, n, -1, -1, 5000);
            n_cmp++;
            if (timed_out || done_idx != exp_done) begin
                n_err++;
                $display("FAIL rand%0d_done: n %0d got idx %0d want %0d",
                         k, n, done_idx, exp_done);
            end
            nbad = (rd_q1.size() != exp_rd.size()) ? 1 : 0;
            if (nbad == 0) foreach (exp_rd[i]) if (rd_q1[i] != exp_rd[i]) nbad++;
            n_cmp++;
            if (nbad != 0) begin
                n_err++;
                $display("FAIL rand%0d_reads: got %0d reads want %0d in order",
                         k, rd_q1.size(), exp_rd.size());
            end
            nbad = 0;
            foreach (exp_w[i]) if (i >= wave.size() || wave[i] !== exp_w[i]) nbad++;
            n_cmp++;
            if (nbad != 0) begin
                n_err++;
                $display("FAIL rand%0d_wave: got %0d bad cycles want 0", k, nbad);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < C*L; i++) mem[i] = '0;
        test_reset();
        test_two_led();
        test_zero_leds();
        test_clamp();
        test_start_ignored();
        test_reset_mid_send();
        test_single_led();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ws2812_multi_tx.md
WS2812_MULTI_TX -- requirements
Module: ws2812_multi_tx

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of parallel LED strings.
REQ-002 SHALL have parameter LEDS_PER_CH, default 64: maximum LEDs per string.
REQ-003 SHALL have parameter ADDR_W, default 13: pixel memory address width.
REQ-004 SHALL have timing parameters, all in clk_sb cycles at 48 MHz: T0H=17, T1H=34, TBIT=60, TLATCH=2880.
REQ-005 SHALL have port clk_sb, input, 1 bit: sole clock.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to begin a frame.
REQ-008 SHALL have port n_leds, input, ADDR_W bits: LEDs per string for this frame, sampled when start is accepted.
REQ-009 SHALL have port busy, output, 1 bit: frame in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.
REQ-011 SHALL have port mem_rd_en, output, 1 bit: pixel read strobe.
REQ-012 SHALL have port mem_addr, output, ADDR_W bits: pixel address.
REQ-013 SHALL have port mem_rd_data, input, PIX_W bits: pixel word, valid exactly 1 cycle after mem_rd_en.
REQ-014 SHALL have port led_out, output, CHANNELS bits: one WS2812 data line per string.

Function
REQ-015 SHALL use PIX_W=24 (GRB) unless RGBW_EN applies (see REQ-031).
REQ-016 SHALL implement states IDLE, PREFETCH, SEND, LATCH.
- IDLE->PREFETCH on start.
- PREFETCH->SEND when all CHANNELS words are loaded.
- SEND->LATCH after the last bit of the last LED.
- LATCH->IDLE after TLATCH cycles.
REQ-017 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-018 SHALL latch n_leds at accept and clamp it to LEDS_PER_CH.
REQ-019 If the latched n_leds is 0, SHALL go IDLE->LATCH directly, with no memory reads.
REQ-020 SHALL use address ch*LEDS_PER_CH + led for channel ch, LED led.
REQ-021 SHALL issue reads in channel order 0..CHANNELS-1 on consecutive cycles.
REQ-022 SHALL hold busy high from the cycle after accept until done.
REQ-023 SHALL drive all channels bit-synchronously, MSB first, one bit per TBIT cycles.
REQ-024 SHALL drive led_out[ch] high for T1H cycles on a 1 bit or T0H cycles on a 0 bit, then low for the rest of TBIT.
REQ-025 SHALL prefetch the next LED's CHANNELS words into a shadow buffer during the first bit period of the current LED.
REQ-026 SHALL load the shadow buffer into the shift registers with no idle gap between LEDs; the first pixel of a frame SHALL rise exactly 1 cycle after PREFETCH ends.
REQ-027 SHALL hold led_out low throughout IDLE, PREFETCH and LATCH.
REQ-028 SHALL pulse done for 1 cycle on the last LATCH cycle and deassert busy in the same cycle.

Reset
REQ-029 SHALL, on reset_n low and asynchronously, force: state=IDLE, led_out=0, busy=0, done=0, mem_rd_en=0, mem_addr=0, and all counters and buffers=0.
REQ-030 SHALL, on reset mid-frame, abandon the frame with no done pulse; the next start SHALL begin from LED 0.

Configuration
REQ-031 SHALL compile RGBW support when macro WS2812_RGBW_EN is defined.
- Defined: PIX_W=32 (GRBW), 32 bits per LED.
- Undefined: PIX_W=24, 24 bits per LED.

Verification
REQ-032 Bench SHALL cover: CHANNELS=4, n_leds=2, ch0 data 0xFF0000/0x000001 -> ch0 shows 8 highs of 34 cycles then 16 highs of 17 cycles, then 23x17 and 1x34; done after 2*24*60+TLATCH cycles.
REQ-033 Bench SHALL cover: n_leds=0 -> no mem_rd_en; done 2880 cycles after accept; led_out stays 0.
REQ-034 Bench SHALL cover: n_leds=100 with LEDS_PER_CH=64 -> exactly 64*4 reads; last read address is 3*64+63=255.
REQ-035 Bench SHALL cover: start pulsed during SEND -> ignored; frame length and read count unchanged.
REQ-036 Bench SHALL cover: reset_n low mid-SEND -> led_out and busy 0 immediately; no done; restart reads address 0 first.
REQ-037 Bench SHALL cover: WS2812_RGBW_EN defined, n_leds=1 -> 32 bit periods per channel; done after 32*60+2880 cycles.
